exp_operand_loader: RTL and testbench

EXP_OPERAND_LOADER -- requirements
Module: exp_operand_loader

---
 rtl/exp_operand_loader.sv | 156 +++++++++++++++
 tb/tb_exp_operand_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_operand_loader.sv
// Streams five OPW-bit operands in over a BUSW-wide bus, holds them steady while the
// exponentiation core runs, then streams the captured result back out LSW first.
module exp_operand_loader #(
  parameter int OPW  = 512,
  parameter int BUSW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [BUSW-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [BUSW-1:0] m_data,
  output logic            m_last,
  output logic            busy,
  output logic            startExponentiation,
  output logic            multiplication_enable,
  output logic [OPW-1:0]  x,
  output logic [OPW-1:0]  exponent,
  output logic [OPW-1:0]  modulus,
  output logic [OPW-1:0]  Rmodm,
  output logic [OPW-1:0]  Rsquaredmodm,
  input  logic            done,
  input  logic [OPW-1:0]  A_result
);

  localparam int N      = OPW / BUSW;
  localparam int TOTAL  = 5 * N;
  localparam int CNT_W  = ($clog2(TOTAL) > 7) ? $clog2(TOTAL) : 7;
  localparam int WSEL_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {LOAD, RUN, UNLOAD} state_e;
  typedef enum logic [2:0] {OP_X, OP_E, OP_M, OP_R, OP_R2} op_e;

  state_e            state_q, state_d;
  op_e               op_sel_q, op_sel_d;
  logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
  logic [WSEL_W-1:0] word_sel_q, word_sel_d;
  logic [WSEL_W-1:0] out_sel_q, out_sel_d;
  logic              start_q, start_d;
  logic [OPW-1:0]    result_q, result_d;
  logic [OPW-1:0]    x_q, x_d, e_q, e_d, m_q, m_d, r_q, r_d, r2_q, r2_d;

  always_comb begin
    // NOTE: every *_d starts as its *_q so no path through this block can infer a latch.
    state_d    = state_q;
    op_sel_d   = op_sel_q;
    load_cnt_d = load_cnt_q;
    word_sel_d = word_sel_q;
    out_sel_d  = out_sel_q;
    result_d   = result_q;
    x_d        = x_q;
    e_d        = e_q;
    m_d        = m_q;
    r_d        = r_q;
    r2_d       = r2_q;

    unique case (state_q)
      LOAD: begin
        if (s_valid) begin
          // Only the addressed word changes; the rest of the operand keeps its old bits.
          case (op_sel_q)
            OP_X:    x_d[word_sel_q*BUSW +: BUSW]  = s_data;
            OP_E:    e_d[word_sel_q*BUSW +: BUSW]  = s_data;
            OP_M:    m_d[word_sel_q*BUSW +: BUSW]  = s_data;
            OP_R:    r_d[word_sel_q*BUSW +: BUSW]  = s_data;
            OP_R2:   r2_d[word_sel_q*BUSW +: BUSW] = s_data;
            default: ;
          endcase
          if (load_cnt_q == CNT_W'(TOTAL - 1)) begin
            load_cnt_d = '0;
            word_sel_d = '0;
            op_sel_d   = OP_X;
            state_d    = RUN;
          end else begin
            load_cnt_d = load_cnt_q + CNT_W'(1);
            if (word_sel_q == WSEL_W'(N - 1)) begin
              word_sel_d = '0;
              op_sel_d   = op_e'(op_sel_q + 3'd1);
            end else begin
              word_sel_d = word_sel_q + WSEL_W'(1);
            end
          end
        end
      end
      RUN: begin
        if (done) begin
          result_d  = A_result;
          out_sel_d = '0;
          state_d   = UNLOAD;
        end
      end
      UNLOAD: begin
        if (m_ready) begin
          if (out_sel_q == WSEL_W'(N - 1)) begin
            out_sel_d = '0;
            state_d   = LOAD;
          end else begin
            out_sel_d = out_sel_q + WSEL_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    start_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: the wide operand and result registers are cleared too, because a reset
      // must leave the core with all-zero operands rather than a stale previous load.
      state_q    <= LOAD;
      op_sel_q   <= OP_X;
      load_cnt_q <= '0;
      word_sel_q <= '0;
      out_sel_q  <= '0;
      start_q    <= 1'b0;
      result_q   <= '0;
      x_q        <= '0;
      e_q        <= '0;
      m_q        <= '0;
      r_q        <= '0;
      r2_q       <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      state_q    <= state_d;
      op_sel_q   <= op_sel_d;
      load_cnt_q <= load_cnt_d;
      word_sel_q <= word_sel_d;
      out_sel_q  <= out_sel_d;
      start_q    <= start_d;
      result_q   <= result_d;
      x_q        <= x_d;
      e_q        <= e_d;
      m_q        <= m_d;
      r_q        <= r_d;
      r2_q       <= r2_d;
    end
  end

  assign s_ready               = (state_q == LOAD);
  assign busy                  = (state_q != LOAD);
  assign m_valid               = (state_q == UNLOAD);
  assign m_data                = m_valid ? result_q[out_sel_q*BUSW +: BUSW] : '0;
  assign m_last                = m_valid && (out_sel_q == WSEL_W'(N - 1));
  assign startExponentiation   = start_q;
  assign multiplication_enable = start_q;
  assign x                     = x_q;
  assign exponent              = e_q;
  assign modulus               = m_q;
  assign Rmodm                 = r_q;
  assign Rsquaredmodm          = r2_q;

endmodule

// File: tb/tb_exp_operand_loader.sv
// Self-checking bench: a transaction-level model predicts every output each cycle,
// plus literal checks on reset values, latency points and reconstructed results.
module tb_exp_operand_loader;

  localparam int OPW  = 512;
  localparam int BUSW = 32;
  localparam int N    = OPW / BUSW;

  logic            clk;
  logic            resetn;
  logic            s_valid;
  logic            s_ready;
  logic [BUSW-1:0] s_data;
  logic            m_valid;
  logic            m_ready;
  logic [BUSW-1:0] m_data;
  logic            m_last;
  logic            busy;
  logic            startExponentiation;
  logic            multiplication_enable;
  logic [OPW-1:0]  x, exponent, modulus, Rmodm, Rsquaredmodm;
  logic            done;
  logic [OPW-1:0]  A_result;

  exp_operand_loader #(.OPW(OPW), .BUSW(BUSW)) dut (
    .clk                   (clk),
    .resetn                (resetn),
    .s_valid               (s_valid),
    .s_ready               (s_ready),
    .s_data                (s_data),
    .m_valid               (m_valid),
    .m_ready               (m_ready),
    .m_data                (m_data),
    .m_last                (m_last),
    .busy                  (busy),
    .startExponentiation   (startExponentiation),
    .multiplication_enable (multiplication_enable),
    .x                     (x),
    .exponent              (exponent),
    .modulus               (modulus),
    .Rmodm                 (Rmodm),
    .Rsquaredmodm          (Rsquaredmodm),
    .done                  (done),
    .A_result              (A_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = loading, 1 = core running, 2 = unloading.
  int             ph    = 0;
  int             mcnt  = 0;
  int             moidx = 0;
  bit             mlive = 0;
  logic [OPW-1:0] mops [5];
  logic [OPW-1:0] mres;

  always @(posedge clk) begin
    if (!resetn) begin
      ph = 0; mcnt = 0; moidx = 0; mres = '0; mlive = 1;
      for (int i = 0; i < 5; i++) mops[i] = '0;
    end else if (mlive) begin
      case (ph)
        0: if (s_valid) begin
             mops[mcnt / N][(mcnt % N)*BUSW +: BUSW] = s_data;
             mcnt++;
             if (mcnt == 5*N) begin mcnt = 0; ph = 1; end
           end
        1: if (done) begin mres = A_result; moidx = 0; ph = 2; end
        default: if (m_ready) begin
             if (moidx == N-1) ph = 0;
             else moidx++;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (mlive) begin
      check("s_ready", s_ready, ph == 0);
      check("busy", busy, ph != 0);
      check("start", startExponentiation, ph == 1);
      check("mult_en", multiplication_enable, ph == 1);
      check("m_valid", m_valid, ph == 2);
      check("m_last", m_last, (ph == 2) && (moidx == N-1));
      if (ph == 2) check("m_data", m_data, mres[moidx*BUSW +: BUSW]);
      check("x", x, mops[0]);
      check("exponent", exponent, mops[1]);
      check("modulus", modulus, mops[2]);
      check("Rmodm", Rmodm, mops[3]);
      check("Rsquaredmodm", Rsquaredmodm, mops[4]);
    end
  end

  function automatic logic [OPW-1:0] mk(input logic [31:0] seed, input logic [15:0] top,
                                        input logic [15:0] bot);
    logic [OPW-1:0] v;
    logic [31:0]    w;
    w = seed;
    v = '0;
    for (int k = 0; k < N; k++) begin
      w = w * 32'h0019660d + 32'h3c6ef35f;
      v[k*BUSW +: BUSW] = w;
    end
    v[OPW-1 -: 16] = top;
    v[15:0]        = bot;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input logic [OPW-1:0] ops [5], input int nwords,
                            input bit gaps, input int done_at);
    for (int i = 0; i < nwords; i++) begin
      if (gaps && ($urandom_range(1, 0) == 1)) begin
        s_valid = 1'b0;
        s_data  = $urandom;
        tick();
      end
      s_valid  = 1'b1;
      s_data   = ops[i / N][(i % N)*BUSW +: BUSW];
      done     = (i == done_at);
      A_result = {OPW{1'b1}};
      tick();
      done = 1'b0;
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic run_core(input logic [OPW-1:0] res);
    int w;
    w = 0;
    while (!startExponentiation && w < 20) begin tick(); w++; end
    check("start_seen", startExponentiation, 1'b1);
    repeat (100) tick();
    done     = 1'b1;
    A_result = res;
    tick();
    done     = 1'b0;
    A_result = ~res;
    check("m_valid_after_done", m_valid, 1'b1);
    check("start_after_done", startExponentiation, 1'b0);
  endtask

  task automatic unload(input logic [OPW-1:0] res, input int stall_word);
    logic [OPW-1:0] got;
    int rx, cyc, stall;
    got = '0; rx = 0; cyc = 0; stall = 0;
    while (rx < N && cyc < 500) begin
      m_ready = !(rx == stall_word && stall < 20);
      if (rx == stall_word && !m_ready) stall++;
      if (m_valid && m_ready) begin
        got[rx*BUSW +: BUSW] = m_data;
        check("m_last_pos", m_last, rx == N-1);
        rx++;
      end
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    check("unload_count", rx, N);
    check("s_ready_after_last", s_ready, 1'b1);
    check("result", got, res);
  endtask

  task automatic check_reset_outputs();
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_data", m_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_start", startExponentiation, 1'b0);
    check("rst_mult_en", multiplication_enable, 1'b0);
    check("rst_x", x, '0);
    check("rst_exponent", exponent, '0);
    check("rst_rsq", Rsquaredmodm, '0);
  endtask

  logic [OPW-1:0] op_a [5];
  logic [OPW-1:0] op_b [5];
  logic [OPW-1:0] op_c [5];
  logic [OPW-1:0] res_a, res_b, res_c;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    done = 1'b0; A_result = '0;

    op_a[0] = mk(32'h1234_5678, 16'hcc3a, 16'h987d);
    op_a[1] = 512'hb7;
    op_a[2] = mk(32'hdead_beef, 16'ha122, 16'h9c4d);
    op_a[3] = mk(32'h0bad_f00d, 16'h5edd, 16'h63b3);
    op_a[4] = mk(32'hfeed_c0de, 16'h0e1f, 16'h2a49);
    res_a   = mk(32'h5555_aaaa, 16'h5764, 16'hcdec);
    for (int i = 0; i < 5; i++) begin
      op_b[i] = mk(32'h1111_0000 + i, 16'h8000 + 16'(i), 16'h0001 + 16'(i));
      op_c[i] = mk(32'h2222_0000 + i, 16'h7fff - 16'(i), 16'hfff0 + 16'(i));
    end
    res_b = mk(32'h0f0f_0f0f, 16'h4321, 16'h8765);
    res_c = mk(32'h3c3c_3c3c, 16'hffff, 16'h0000);

    repeat (3) tick();
    check_reset_outputs();
    resetn = 1'b1;
    tick();

    // Reference operation, then literal pins on the model's inputs and outputs.
    load_words(op_a, 5*N, 1'b0, -1);
    check("start_T+1", startExponentiation, 1'b1);
    check("busy_run", busy, 1'b1);
    check("x_msh", x[OPW-1 -: 16], 16'hcc3a);
    check("x_lsh", x[15:0], 16'h987d);
    check("exp_lit", exponent, 512'hb7);
    check("mod_lsh", modulus[15:0], 16'h9c4d);
    run_core(res_a);
    check("m_data_w0_lit", m_data[15:0], 16'hcdec);
    unload(res_a, -1);

    // Gappy load with a stray done, then a stalled unload, then back-to-back.
    load_words(op_b, 5*N, 1'b1, 40);
    check("gappy_x", x, op_b[0]);
    check("gappy_rsq", Rsquaredmodm, op_b[4]);
    run_core(res_b);
    unload(res_b, 3);
    load_words(op_c, 5*N, 1'b0, -1);
    run_core(res_c);
    unload(res_c, -1);

    // Reset during RUN, reset during a partial load, then a clean operation.
    load_words(op_a, 5*N, 1'b0, -1);
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_reset_outputs();
    load_words(op_c, 10, 1'b0, -1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_reset_outputs();
    load_words(op_b, 5*N, 1'b0, -1);
    check("reload_x", x, op_b[0]);
    check("reload_mod", modulus, op_b[2]);
    run_core(res_a);
    unload(res_a, 0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
